motion_sequencer: RTL and testbench



---
 rtl/motion_sequencer.sv | 165 ++++++++++++++++
 tb/tb_motion_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_sequencer.sv
// Waypoint scheduler: buffers joint-space goals, slews the joint targets at a
// bounded rate, waits for encoder arrival and raises a sticky fault on timeout.
module motion_sequencer #(
   parameter int DEPTH   = 4,
   parameter int STEP    = 8,
   parameter int TOL     = 2,
   parameter int SETTLE  = 16,
   parameter int TIMEOUT = 4096
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [9:0] cmd_j1,
   input  logic [9:0] cmd_j2,
   input  logic [9:0] cmd_j3,
   input  logic [9:0] enc1,
   input  logic [9:0] enc2,
   input  logic [9:0] enc3,
   input  logic       abort,
   output logic [9:0] target1,
   output logic [9:0] target2,
   output logic [9:0] target3,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [7:0] wp_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(SETTLE + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SLEW, S_SETTLE, S_DONE, S_FAULT
   } state_t;

   state_t        state, state_next;
   logic [29:0]   fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] fifo_count, count_next;
   logic [9:0]    g1, g2, g3;
   logic [9:0]    slew1, slew2, slew3;
   logic [TW-1:0] timeout_cnt;
   logic [SW-1:0] settle_cnt;
   logic          full, push, pop, flush;
   logic          arrived, in_tol, timed_out, settled;

   function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
      return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
   endfunction

   // One rate-limited step of t toward g; a target already at its goal holds.
   function automatic logic [9:0] slew_toward(input logic [9:0] t, input logic [9:0] g);
      logic [10:0] d;
      logic [9:0]  s;
      d = abs_diff(g, t);
      s = (d < 11'(STEP)) ? d[9:0] : 10'(STEP);
      return (g >= t) ? t + s : t - s;
   endfunction

   assign full      = (fifo_count == CW'(DEPTH));
   assign cmd_ready = !full && !fault;

   assign slew1 = slew_toward(target1, g1);
   assign slew2 = slew_toward(target2, g2);
   assign slew3 = slew_toward(target3, g3);

   assign arrived   = (slew1 == g1) && (slew2 == g2) && (slew3 == g3);
   assign in_tol    = (abs_diff(enc1, g1) <= 11'(TOL)) &&
                      (abs_diff(enc2, g2) <= 11'(TOL)) &&
                      (abs_diff(enc3, g3) <= 11'(TOL));
   assign timed_out = (timeout_cnt == TW'(TIMEOUT - 1));
   assign settled   = in_tol && (settle_cnt == SW'(SETTLE - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Timeout wins over arrival; abort wins over everything.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (fifo_count != '0) state_next = S_LOAD;
         S_LOAD:   state_next = S_SLEW;
         S_SLEW:   if (timed_out) state_next = S_FAULT;
                   else if (arrived) state_next = S_SETTLE;
         S_SETTLE: if (timed_out) state_next = S_FAULT;
                   else if (settled) state_next = S_DONE;
         S_DONE:   state_next = S_IDLE;
         S_FAULT:  state_next = S_FAULT;
         default:  state_next = S_IDLE;
      endcase
      if (abort) state_next = S_IDLE;
   end

   assign pop   = (state == S_IDLE) && (fifo_count != '0) && !abort;
   assign flush = abort || ((state_next == S_FAULT) && (state != S_FAULT));
   assign push  = cmd_valid && cmd_ready && !flush;

   always_comb begin
      count_next = fifo_count;
      if (flush)              count_next = '0;
      else if (push && !pop)  count_next = fifo_count + CW'(1);
      else if (pop && !push)  count_next = fifo_count - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {cmd_j1, cmd_j2, cmd_j3};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         fifo_count <= count_next;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         g1          <= '0;
         g2          <= '0;
         g3          <= '0;
         target1     <= '0;
         target2     <= '0;
         target3     <= '0;
         timeout_cnt <= '0;
         settle_cnt  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         fault       <= 1'b0;
         wp_count    <= '0;
      end else begin
         if (pop) {g1, g2, g3} <= fifo_mem[rd_ptr];
         if ((state == S_SLEW) && !abort) begin
            target1 <= slew1;
            target2 <= slew2;
            target3 <= slew3;
         end
         if (abort || (state == S_LOAD)) begin
            timeout_cnt <= '0;
            settle_cnt  <= '0;
         end else if ((state == S_SLEW) || (state == S_SETTLE)) begin
            timeout_cnt <= timeout_cnt + TW'(1);
            if (state == S_SETTLE) settle_cnt <= in_tol ? settle_cnt + SW'(1) : '0;
         end
         // Outputs are registered from the next state so they line up with it.
         done  <= (state_next == S_DONE);
         fault <= (state_next == S_FAULT);
         busy  <= (state_next inside {S_LOAD, S_SLEW, S_SETTLE, S_DONE}) || (count_next != '0);
         if (state_next == S_DONE) wp_count <= wp_count + 8'd1;
      end
   end
endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer: hand-computed targets, done timing,
// FIFO back-pressure, timeout fault, abort and asynchronous reset.
module tb_motion_sequencer;
   logic       clk = 1'b0;
   logic       reset, cmd_valid, abort;
   logic [9:0] cmd_j1, cmd_j2, cmd_j3;
   logic [9:0] enc1, enc2, enc3;
   logic [9:0] target1, target2, target3;
   logic       cmd_ready, busy, done, fault;
   logic [7:0] wp_count;

   int checks = 0;
   int errors = 0;
   int waited;

   // Encoders either follow the targets with a two-cycle lag or are pinned.
   logic       enc_pinned = 1'b0;
   logic [9:0] pin1 = '0, pin2 = '0, pin3 = '0;
   logic [9:0] lag_a1 = '0, lag_a2 = '0, lag_a3 = '0;
   logic [9:0] lag_b1 = '0, lag_b2 = '0, lag_b3 = '0;

   motion_sequencer dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_j1(cmd_j1), .cmd_j2(cmd_j2), .cmd_j3(cmd_j3),
      .enc1(enc1), .enc2(enc2), .enc3(enc3), .abort(abort),
      .target1(target1), .target2(target2), .target3(target3),
      .busy(busy), .done(done), .fault(fault), .wp_count(wp_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      lag_a1 <= target1; lag_a2 <= target2; lag_a3 <= target3;
      lag_b1 <= lag_a1;  lag_b2 <= lag_a2;  lag_b3 <= lag_a3;
   end

   assign enc1 = enc_pinned ? pin1 : lag_b1;
   assign enc2 = enc_pinned ? pin2 : lag_b2;
   assign enc3 = enc_pinned ? pin3 : lag_b3;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pin(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
      pin1 = a; pin2 = b; pin3 = c;
   endtask

   // Offers one waypoint and returns after the edge that accepts it.
   task automatic push_wp(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                          input int budget, output int n);
      n = 0;
      cmd_valid = 1'b1; cmd_j1 = a; cmd_j2 = b; cmd_j3 = c;
      while (!cmd_ready && n < budget) begin
         step();
         n++;
      end
      check("push_accept_in_budget", (n < budget), 1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check({tag, "_done_seen"}, done, 1);
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
      cmd_j1 = '0; cmd_j2 = '0; cmd_j3 = '0;
      step(); step();
      check("rst_target1", target1, 0);
      check("rst_target3", target3, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_fault", fault, 0);
      check("rst_wp_count", wp_count, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      reset = 1'b0;
      step(); step();

      // Single waypoint (20,0,1023) with lagged encoders.
      push_wp(10'd20, 10'd0, 10'd1023, 10, waited);
      check("wp1_busy_after_push", busy, 1);
      step(); step();
      check("wp1_t1_at_slew_entry", target1, 0);
      step();
      check("wp1_t1_step1", target1, 8);
      check("wp1_t3_step1", target3, 8);
      step();
      check("wp1_t1_step2", target1, 16);
      step();
      check("wp1_t1_step3", target1, 20);
      check("wp1_t2_hold", target2, 0);
      check("wp1_t3_step3", target3, 24);
      repeat (124) step();
      check("wp1_t3_step127", target3, 1016);
      step();
      check("wp1_t3_final", target3, 1023);
      repeat (17) step();
      check("wp1_done_not_early", done, 0);
      step();
      check("wp1_done_pulse", done, 1);
      check("wp1_busy_in_done", busy, 1);
      step();
      check("wp1_done_one_cycle", done, 0);
      check("wp1_busy_falls", busy, 0);
      check("wp1_wp_count", wp_count, 1);

      // Settle disturbance at the tolerance boundary.
      enc_pinned = 1'b1; pin(10'd0, 10'd0, 10'd0);
      push_wp(10'd28, 10'd0, 10'd1023, 10, waited);
      step(); step(); step();
      check("dist_t1", target1, 28);
      pin(10'd30, 10'd0, 10'd1021);
      repeat (10) step();
      pin1 = 10'd31;
      step();
      pin1 = 10'd30;
      repeat (15) step();
      check("dist_done_not_early", done, 0);
      step();
      check("dist_done_pulse", done, 1);
      step();
      check("dist_wp_count", wp_count, 2);

      // FIFO back-pressure with the first waypoint held in SETTLE.
      pin(10'd0, 10'd0, 10'd0);
      push_wp(10'd40, 10'd0, 10'd1023, 10, waited);
      push_wp(10'd48, 10'd8, 10'd1015, 10, waited);
      push_wp(10'd56, 10'd16, 10'd1007, 10, waited);
      push_wp(10'd64, 10'd24, 10'd999, 10, waited);
      push_wp(10'd72, 10'd32, 10'd991, 10, waited);
      check("full_ready_low", cmd_ready, 0);
      check("full_busy", busy, 1);
      repeat (3) step();
      check("full_ready_stays_low", cmd_ready, 0);
      enc_pinned = 1'b0;
      wait_done("fifo_w1", 100);
      check("fifo_w1_t1", target1, 40);
      push_wp(10'd80, 10'd40, 10'd983, 20, waited);
      check("fifo_w6_waits_for_pop", waited, 2);
      wait_done("fifo_w2", 100);
      check("fifo_w2_t1", target1, 48);
      check("fifo_w2_t2", target2, 8);
      check("fifo_w2_t3", target3, 1015);
      step();
      wait_done("fifo_w3", 100);
      check("fifo_w3_t1", target1, 56);
      step();
      wait_done("fifo_w4", 100);
      check("fifo_w4_t1", target1, 64);
      step();
      wait_done("fifo_w5", 100);
      check("fifo_w5_t1", target1, 72);
      step();
      wait_done("fifo_w6", 100);
      check("fifo_w6_t1", target1, 80);
      check("fifo_w6_t3", target3, 983);
      step();
      check("fifo_wp_count", wp_count, 8);
      check("fifo_busy_clear", busy, 0);

      // Timeout with encoders pinned at zero.
      enc_pinned = 1'b1; pin(10'd0, 10'd0, 10'd0);
      push_wp(10'd100, 10'd100, 10'd100, 10, waited);
      repeat (4097) step();
      check("to_fault_not_early", fault, 0);
      step();
      check("to_fault_set", fault, 1);
      check("to_t1_hold", target1, 100);
      check("to_t3_hold", target3, 100);
      check("to_ready_low", cmd_ready, 0);
      check("to_busy_low", busy, 0);
      cmd_valid = 1'b1; cmd_j1 = 10'd5; cmd_j2 = 10'd5; cmd_j3 = 10'd5;
      repeat (3) step();
      check("to_push_ignored", busy, 0);
      check("to_fault_sticky", fault, 1);
      abort = 1'b1;
      step();
      abort = 1'b0; cmd_valid = 1'b0;
      check("to_abort_clears_fault", fault, 0);
      check("to_abort_ready", cmd_ready, 1);
      check("to_abort_t1", target1, 100);
      step();
      check("to_abort_idle", busy, 0);

      // Abort mid-SLEW with two waypoints buffered and a push in the same cycle.
      push_wp(10'd900, 10'd100, 10'd100, 10, waited);
      push_wp(10'd0, 10'd0, 10'd0, 10, waited);
      push_wp(10'd500, 10'd500, 10'd500, 10, waited);
      step(); step(); step();
      check("ab_t1_before", target1, 124);
      abort = 1'b1;
      cmd_valid = 1'b1; cmd_j1 = 10'd700; cmd_j2 = 10'd700; cmd_j3 = 10'd700;
      step();
      abort = 1'b0; cmd_valid = 1'b0;
      check("ab_t1_frozen", target1, 124);
      check("ab_t2_frozen", target2, 100);
      check("ab_busy_low", busy, 0);
      check("ab_no_done", done, 0);
      waited = 0;
      repeat (10) begin
         step();
         if (done === 1'b1) waited++;
      end
      check("ab_no_done_later", waited, 0);
      check("ab_t1_still_frozen", target1, 124);
      check("ab_fifo_empty", busy, 0);

      // Asynchronous reset mid-SETTLE, then a waypoint equal to the targets.
      pin(10'd0, 10'd0, 10'd0);
      push_wp(10'd130, 10'd100, 10'd100, 10, waited);
      step(); step(); step();
      check("rs_t1_before", target1, 130);
      repeat (5) step();
      #3 reset = 1'b1;
      #1;
      check("rs_async_t1", target1, 0);
      check("rs_async_t2", target2, 0);
      check("rs_async_busy", busy, 0);
      check("rs_async_wp_count", wp_count, 0);
      check("rs_async_ready", cmd_ready, 1);
      @(posedge clk);
      #1 reset = 1'b0;
      enc_pinned = 1'b0;
      repeat (3) step();
      push_wp(10'd0, 10'd0, 10'd0, 10, waited);
      repeat (18) step();
      check("eq_done_not_early", done, 0);
      step();
      check("eq_done_pulse", done, 1);
      step();
      check("eq_wp_count", wp_count, 1);
      check("eq_busy_low", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
